mux4_serializer: RTL and testbench
==================================

MUX4_SERIALIZER -- requirements
Module: mux4_serializer

Interface
REQ-001 Parameter MSB_FIRST, default 0; 0 = bit order I[0],I[1],I[2],I[3]; 1 = bit order I[3],I[2],I[1],I[0].
REQ-002 Parameter HOLD, default 1; cycles each bit is held on ser_out; legal range 1..4.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, synchronous, active-high reset.
REQ-005 Port in_valid, input, 1, upstream offers a 4-bit word.
REQ-006 Port in_data, input, 4, parallel word; data line I[3:0] of the downstream 4:1 mux.
REQ-007 Port in_ready, output, 1, block accepts in_data this cycle.
REQ-008 Port sel, output, 2, select code S[1:0] driven to the downstream 4:1 mux.
REQ-009 Port ser_out, output, 1, serial bit, equal to word[sel] while out_valid=1, else 0.
REQ-010 Port out_valid, output, 1, ser_out carries a frame bit.
REQ-011 Port frame_start, output, 1, one-cycle pulse on the first cycle of the first bit of a frame.
REQ-012 Port frame_done, output, 1, one-cycle pulse on the last cycle of the last bit of a frame.

Function
REQ-013 The block SHALL have two states: IDLE and SHIFT.
REQ-014 In IDLE, in_ready SHALL be 1, out_valid 0, ser_out 0, sel held at the first index: 0 if MSB_FIRST=0, 3 if MSB_FIRST=1.
REQ-015 A transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_data is captured into an internal 4-bit word register and the state moves to SHIFT.
REQ-016 Latency SHALL be one cycle: out_valid=1, frame_start=1 and the first bit appear on the cycle after the transfer.
REQ-017 In SHIFT, each bit SHALL be held for exactly HOLD cycles, tracked by a hold counter running 0..HOLD-1.
REQ-018 sel SHALL step 0->1->2->3 when MSB_FIRST=0, or 3->2->1->0 when MSB_FIRST=1, on the edge where the hold counter wraps.
REQ-019 A frame SHALL last exactly 4*HOLD cycles with out_valid=1 continuously.
REQ-020 in_ready SHALL be 0 in SHIFT except on the frame_done cycle, where it SHALL be 1.
REQ-021 If a transfer occurs on the frame_done cycle, the next frame SHALL start on the next cycle with no idle gap; otherwise the state returns to IDLE.
REQ-022 Changes on in_data or in_valid while in_ready=0 SHALL not affect the word being shifted.
REQ-023 frame_start and frame_done SHALL both be 1 in the same cycle only if HOLD=1 were degenerate; this cannot occur, since a frame spans at least 4 cycles.
REQ-024 All outputs except in_ready SHALL be registered; in_ready SHALL be decoded from state and counters and forced to 0 while rst=1.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL enter IDLE and clear the word, hold counter and out_valid, frame_start and frame_done to 0; sel SHALL be set to its IDLE value.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no frame_done; out_valid=0 on the following cycle.
REQ-027 No transfer SHALL be accepted on a cycle where rst=1.

Verification
REQ-028 MSB_FIRST=0, HOLD=1: send 4'b1011 -> ser_out 1,1,0,1 over 4 cycles with sel 0,1,2,3; frame_start on cycle 1 and frame_done on cycle 4 after the transfer.
REQ-029 MSB_FIRST=1, HOLD=2: send 4'b1000 -> ser_out 1,1,0,0,0,0,0,0 with sel 3,3,2,2,1,1,0,0.
REQ-030 Back-to-back: in_valid held at 1 with 4'hA then 4'h5 -> 8 contiguous out_valid cycles giving 0,1,0,1,1,0,1,0; in_ready=1 only on cycles 0 and 4.
REQ-031 Mid-frame change: in_data changed from 4'hF to 4'h0 at bit 2 -> serial output stays 1,1,1,1.
REQ-032 Reset at bit 2 of a frame of 4'hF -> the next cycle shows out_valid=0, ser_out=0 and in_ready=1, with no frame_done pulse.
REQ-033 Exhaustive: all 16 words for each HOLD in 1..4 and each MSB_FIRST value -> ser_out at every cycle equals in_data[sel], checked by a scoreboard.

Source files
------------

// File: rtl/mux4_serializer_if.sv
// Handshake and mux-control bundle for the 4-bit serializer.
// master drives the word in; slave (the serializer) drives the serial side.
interface mux4_serializer_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [1:0] sel;
  logic       ser_out;
  logic       out_valid;
  logic       frame_start;
  logic       frame_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, sel, ser_out,
    input  out_valid, frame_start, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, sel, ser_out,
    output out_valid, frame_start, frame_done
  );
endinterface

// File: rtl/mux4_serializer.sv
// Serializes a 4-bit word through a 4:1 mux select sequence.
// Each bit is held HOLD cycles; back-to-back frames run gap-free.
module mux4_serializer #(
  parameter int MSB_FIRST = 0,
  parameter int HOLD      = 1
) (
  input  logic               clk,
  input  logic               rst,
  mux4_serializer_if.slave   bus
);

  localparam logic [1:0] SEL_FIRST = (MSB_FIRST != 0) ? 2'd3 : 2'd0;
  localparam logic [1:0] SEL_LAST  = (MSB_FIRST != 0) ? 2'd0 : 2'd3;
  localparam int         HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        r_state;
  logic [3:0]    r_word;
  logic [HW-1:0] r_hold;
  logic [1:0]    r_sel;
  logic          r_ser;
  logic          r_valid;
  logic          r_fs;
  logic          r_fd;

  logic          w_wrap;
  logic          w_last;
  logic          w_ready;
  logic          w_xfer;
  logic [1:0]    w_sel_step;
  logic [HW-1:0] w_hold_nxt;
  logic [1:0]    w_sel_nxt;

  assign w_wrap     = (r_hold == HOLD_MAX);
  assign w_last     = (r_state == SHIFT) && w_wrap && (r_sel == SEL_LAST);
  assign w_ready    = !rst && ((r_state == IDLE) || w_last);
  assign w_xfer     = w_ready && bus.in_valid;
  assign w_sel_step = (MSB_FIRST != 0) ? r_sel - 2'd1 : r_sel + 2'd1;
  assign w_hold_nxt = w_wrap ? '0 : r_hold + 1'b1;
  assign w_sel_nxt  = w_wrap ? w_sel_step : r_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_hold  <= '0;
      r_sel   <= SEL_FIRST;
      r_ser   <= 1'b0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
    end else if (w_xfer) begin
      r_state <= SHIFT;
      r_word  <= bus.in_data;
      r_hold  <= '0;
      r_sel   <= SEL_FIRST;
      r_ser   <= bus.in_data[SEL_FIRST];
      r_valid <= 1'b1;
      r_fs    <= 1'b1;
      r_fd    <= 1'b0;
    end else if (w_last || r_state == IDLE) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_sel   <= SEL_FIRST;
      r_ser   <= 1'b0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      // frame_done is registered, so look one cycle ahead
      r_hold  <= w_hold_nxt;
      r_sel   <= w_sel_nxt;
      r_ser   <= r_word[w_sel_nxt];
      r_fs    <= 1'b0;
      r_fd    <= (w_hold_nxt == HOLD_MAX) && (w_sel_nxt == SEL_LAST);
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.sel         = r_sel;
  assign bus.ser_out     = r_ser;
  assign bus.out_valid   = r_valid;
  assign bus.frame_start = r_fs;
  assign bus.frame_done  = r_fd;

endmodule

// File: tb/tb_mux4_serializer.sv
// Lockstep bench: eight serializers (MSB_FIRST x HOLD 1..4) fed the same
// stimulus, each scored every cycle against a frame-position model.
module tb_mux4_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic       rdy_a [8];
  logic [1:0] sel_a [8];
  logic       ser_a [8];
  logic       val_a [8];
  logic       fs_a  [8];
  logic       fd_a  [8];

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 8; g++) begin : g_dut
    localparam int M = g / 4;
    localparam int H = (g % 4) + 1;
    localparam int FL = 4 * H;

    mux4_serializer_if bus ();

    assign bus.in_valid = in_valid;
    assign bus.in_data  = in_data;

    mux4_serializer #(.MSB_FIRST(M), .HOLD(H)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign rdy_a[g] = bus.in_ready;
    assign sel_a[g] = bus.sel;
    assign ser_a[g] = bus.ser_out;
    assign val_a[g] = bus.out_valid;
    assign fs_a[g]  = bus.frame_start;
    assign fd_a[g]  = bus.frame_done;

    // t = cycle offset inside the current frame, -1 when idle
    int         t = -1;
    logic [3:0] w = 4'h0;
    logic       e_rdy;

    assign e_rdy = !rst && (t < 0 || t == FL - 1);

    always @(posedge clk) begin
      if (rst) t <= -1;
      else if (in_valid && e_rdy) begin
        t <= 0;
        w <= in_data;
      end
      else if (t == FL - 1) t <= -1;
      else if (t >= 0) t <= t + 1;
    end

    function automatic int exp_sel(input int tt);
      int k;
      k = (tt < 0) ? 0 : tt / H;
      return (M != 0) ? 3 - k : k;
    endfunction

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("rdy m%0d h%0d", M, H), int'(bus.in_ready), int'(e_rdy));
        check($sformatf("valid m%0d h%0d", M, H), int'(bus.out_valid), int'(t >= 0));
        check($sformatf("sel m%0d h%0d", M, H), int'(bus.sel), exp_sel(t));
        check($sformatf("ser m%0d h%0d", M, H), int'(bus.ser_out),
              (t < 0) ? 0 : int'(w[exp_sel(t)]));
        check($sformatf("fstart m%0d h%0d", M, H), int'(bus.frame_start), int'(t == 0));
        check($sformatf("fdone m%0d h%0d", M, H), int'(bus.frame_done), int'(t == FL - 1));
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] pat;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // LSB-first, HOLD=1, word 1011
    pat = 4'b1101;
    send_one(4'b1011);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("d1 ser", int'(ser_a[0]), int'(pat[3 - k]));
      check("d1 sel", int'(sel_a[0]), k);
      check("d1 fstart", int'(fs_a[0]), int'(k == 0));
      check("d1 fdone", int'(fd_a[0]), int'(k == 3));
    end
    idle(20);

    // MSB-first, HOLD=2, word 1000
    send_one(4'b1000);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("d2 ser", int'(ser_a[5]), int'(k < 2));
      check("d2 sel", int'(sel_a[5]), 3 - k / 2);
      check("d2 valid", int'(val_a[5]), 1);
    end
    idle(20);

    // back-to-back A then 5 on LSB-first HOLD=1
    pat = 4'b0101;
    in_valid = 1'b1;
    in_data  = 4'hA;
    @(posedge clk);
    #1 in_data = 4'h5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b valid", int'(val_a[0]), 1);
      check("b2b ser", int'(ser_a[0]), int'((k < 4) ? pat[3 - k] : pat[7 - k] ^ 1'b1));
      check("b2b rdy", int'(rdy_a[0]), int'(k == 3 || k == 7));
      if (k == 3) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
    idle(20);

    // data changes under a busy frame
    send_one(4'hF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold ser", int'(ser_a[0]), 1);
      if (k == 1) in_data = 4'h0;
    end
    idle(20);

    // reset during bit 2
    send_one(4'hF);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst valid", int'(val_a[0]), 0);
    check("rst ser", int'(ser_a[0]), 0);
    check("rst rdy", int'(rdy_a[0]), 1);
    check("rst fdone", int'(fd_a[0]), 0);
    idle(20);

    // every word, offered long enough for the slowest instance
    for (int wd = 0; wd < 16; wd++) begin
      in_valid = 1'b1;
      in_data  = 4'(wd);
      repeat (17) @(posedge clk);
      #1;
    end
    idle(20);

    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 4'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
